// File: rtl/cnn_classifier.sv
// Streaming K x K convolution (NCH channels, ReLU) into an internal feature RAM,
// followed by a one-MAC-per-cycle fully-connected layer and an arg-max.
module cnn_classifier #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned K     = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned NCLS  = 10,
  parameter int unsigned DW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [K*K*DW-1:0]          i_win,
  input  logic                       i_win_valid,
  output logic                       o_win_ready,
  input  logic [NCH*K*K*WW-1:0]      i_conv_w,
  output logic [$clog2(NCLS*NCH*(IMG_W-K+1)*(IMG_W-K+1))-1:0] o_fc_raddr,
  input  logic [WW-1:0]              i_fc_rdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(NCLS)-1:0]    o_out
);

  localparam int unsigned M     = IMG_W - K + 1;
  localparam int unsigned MM    = M * M;
  localparam int unsigned KK    = K * K;
  localparam int unsigned N     = NCH * MM;
  localparam int unsigned TOT   = NCLS * N;
  localparam int unsigned RA_W  = $clog2(TOT);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CLS_W = $clog2(NCLS);
  localparam int unsigned POS_W = $clog2(MM);
  localparam int unsigned T_W   = $clog2(TOT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FC, S_RESULT} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_win_ready, r_busy, r_done, r_mac_vld;
  logic [CLS_W-1:0]         r_out, r_cls, r_mac_cls, w_best_idx;
  logic [POS_W-1:0]         r_pos;
  logic [T_W-1:0]           r_t;
  logic [IDX_W-1:0]         r_idx;
  logic [RA_W-1:0]          r_fc_raddr;
  logic signed [ACC_W-1:0]  r_feat, w_best;
  logic signed [ACC_W-1:0]  r_score [NCLS];
  logic signed [ACC_W-1:0]  r_fmap  [N];
  logic signed [ACC_W-1:0]  w_relu  [NCH];
  logic                     w_accept, w_last_pos, w_fc_issue;

  assign w_accept   = (r_state == S_CONV) && i_win_valid && r_win_ready;
  assign w_last_pos = (r_pos == POS_W'(MM - 1));
  assign w_fc_issue = (r_state == S_FC) && (r_t != T_W'(TOT));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_CONV;
      S_CONV:   if (w_accept && w_last_pos) w_state_nxt = S_FC;
      S_FC:     if (!w_fc_issue) w_state_nxt = S_RESULT;
      S_RESULT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Per-channel dot product of signed weights with unsigned pixels, then ReLU
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      logic signed [ACC_W-1:0] acc;
      acc = '0;
      for (int j = 0; j < KK; j++) begin
        acc = acc + ACC_W'($signed(i_conv_w[(ch*KK+j)*WW +: WW]))
                  * $signed(ACC_W'(i_win[j*DW +: DW]));
      end
      w_relu[ch] = acc[ACC_W-1] ? '0 : acc;
    end
  end

  // Arg-max with strict compare so ties keep the lower class index
  always_comb begin
    w_best     = r_score[0];
    w_best_idx = '0;
    for (int k = 1; k < NCLS; k++) begin
      if (r_score[k] > w_best) begin
        w_best     = r_score[k];
        w_best_idx = CLS_W'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_fmap[IDX_W'(ch*MM) + IDX_W'(r_pos)] <= w_relu[ch];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out       <= '0;
      r_mac_vld   <= 1'b0;
      r_mac_cls   <= '0;
      r_feat      <= '0;
      r_pos       <= '0;
      r_t         <= '0;
      r_idx       <= '0;
      r_cls       <= '0;
      r_fc_raddr  <= '0;
      for (int k = 0; k < NCLS; k++) r_score[k] <= '0;
    end else begin
      r_win_ready <= (w_state_nxt == S_CONV);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= 1'b0;
      r_mac_vld   <= w_fc_issue;
      if (r_state == S_IDLE && i_start) begin
        r_pos      <= '0;
        r_t        <= '0;
        r_idx      <= '0;
        r_cls      <= '0;
        r_fc_raddr <= '0;
        for (int k = 0; k < NCLS; k++) r_score[k] <= '0;
      end
      if (w_accept) r_pos <= w_last_pos ? '0 : r_pos + POS_W'(1);
      // Issue address t; the feature is fetched now so it lines up with ROM data
      if (w_fc_issue) begin
        r_t        <= r_t + T_W'(1);
        r_fc_raddr <= (r_t == T_W'(TOT - 1)) ? '0 : r_fc_raddr + RA_W'(1);
        r_mac_cls  <= r_cls;
        r_feat     <= r_fmap[r_idx];
        if (r_idx == IDX_W'(N - 1)) begin
          r_idx <= '0;
          r_cls <= r_cls + CLS_W'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (r_mac_vld) begin
        r_score[r_mac_cls] <= r_score[r_mac_cls] + r_feat * ACC_W'($signed(i_fc_rdata));
      end
      if (r_state == S_RESULT) begin
        r_out  <= w_best_idx;
        r_done <= 1'b1;
      end
    end
  end

  assign o_win_ready = r_win_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_out       = r_out;
  assign o_fc_raddr  = r_fc_raddr;

endmodule

// File: doc/cnn_classifier.md
# cnn_classifier

Parametrised successor of the single-channel convolution classifier. Consumes a stream of K×K unsigned pixel windows through a valid/ready handshake and applies NCH convolution kernels with ReLU, storing every feature map internally. It then runs a sequential fully-connected layer with one MAC per cycle, reading weights from an external synchronous ROM, and reports the arg-max class. It sits between the window-extraction front end and the result/display logic.

## Interface
- IMG_W, 28: input image width and height (square).
- K, 5: kernel size; feature map side M = IMG_W-K+1.
- NCH, 2: number of convolution channels.
- NCLS, 10: number of output classes.
- DW, 8: pixel width, unsigned.
- WW, 8: weight width, signed, for both conv and FC weights.
- ACC_W, 32: signed accumulator and feature width.
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  starts one inference; sampled only in IDLE.
- WIN  in  K*K*DW  pixel window, element (r,c) at bits [(r*K+c)*DW +: DW].
- WIN_VALID  in  1  WIN is valid.
- WIN_READY  out  1  block accepts WIN this cycle.
- CONV_W  in  NCH*K*K*WW  conv kernels, element (ch,r,c) at index (ch*K*K+r*K+c); must be held stable while BUSY.
- FC_RADDR  out  clog2(NCLS*NCH*M*M)  FC weight address.
- FC_RDATA  in  WW  FC weight, valid one cycle after FC_RADDR.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when OUT is updated.
- OUT  out  clog2(NCLS)  winning class index.

## Operation
- States: IDLE → CONV → FC → RESULT → IDLE.
- IDLE: WIN_READY=0. On START, clear the position counter and all NCLS score accumulators, then go to CONV.
- CONV: WIN_READY=1. A window is accepted when WIN_VALID&&WIN_READY. Windows arrive in row-major order, position p = y*M+x, p = 0..M*M-1.
  - For each accepted window and each channel ch: sum = Σ CONV_W(ch,r,c)·WIN(r,c), signed ACC_W with two's-complement wrap.
  - ReLU: store max(sum,0) into fmap[ch*M*M+p].
  - After window p = M*M-1 is accepted, go to FC with the counter t cleared.
  - No accepted window means no progress; bubbles are allowed.
- FC: let N = NCH*M*M. FC_RADDR = t for t = 0..NCLS*N-1, where class = t/N and feature index i = t%N.
  - One cycle later: score[class] += FC_RDATA·fmap[i], with ACC_W wrap.
  - The state lasts NCLS*N+1 cycles; the last cycle is drain-only.
  - FC_RADDR holds 0 outside FC.
- RESULT: one cycle. OUT = lowest index k with score[k] maximal (strict > comparison, so ties go to the lower index). Register OUT, pulse DONE, go to IDLE.
- OUT holds its value until the next RESULT.
- START outside IDLE is ignored. START in the same cycle as DONE is honoured, because the state is already IDLE.
- RST in any state: state=IDLE, WIN_READY=0, BUSY=0, DONE=0, OUT=0, FC_RADDR=0, counters=0. A partial inference is discarded. Feature RAM contents are not reset.

## Timing
- Reset values: DONE=0, OUT=0, BUSY=0, WIN_READY=0, FC_RADDR=0.
- START accepted at cycle 0 → CONV from cycle 1.
- With WIN_VALID held high, windows are accepted at cycles 1..M*M.
- FC occupies cycles M*M+1 .. M*M+NCLS*N+1.
- RESULT occupies cycle M*M+NCLS*N+2.
- DONE is high and OUT is valid at cycle M*M+NCLS*N+3, for exactly one cycle.
- Each stall cycle (WIN_VALID=0 in CONV) adds one cycle of latency.
- Conv result is written in the accept cycle; there is no conv pipeline.

## Test plan
- Config IMG_W=6, K=3, NCH=2, NCLS=4 (M=4, N=32). Stimulus: START with all pixels 1, all conv weights +1, FC weights = class index+1 → every fmap entry is 9; scores 288/576/864/1152; OUT=3; DONE exactly at cycle 147 after START.
- Same config, conv ch0 weights all −1 and ch1 weights all +1, FC weights nonzero only for class 1 → ch0 features clamp to 0; OUT=1.
- FC weights all equal for every class → all scores tie; OUT=0 (lowest index).
- WIN_VALID low for 5 cycles mid-CONV → WIN_READY stays high, no position advance, DONE at cycle 152, OUT unchanged from the unstalled run.
- START pulsed during CONV and during FC → ignored; BUSY stays high; result identical to the undisturbed run.
- RST asserted for one cycle in the middle of FC → the next cycle shows BUSY=0, OUT=0, DONE=0 and no DONE pulse; a new START then completes with the correct OUT.
